// File: rtl/quot_res_recon_if.sv
// Handshake bundle for the quotient/residue reconstructor.
//   master : producer of (q_in, r_in) and consumer of (x_out, flags)
//   slave  : the reconstructor itself
// Input side : in_valid/in_ready with q_in (W bits) and r_in (RW bits).
// Output side: out_valid/out_ready with x_out (W bits), ovf, rem_err.
interface quot_res_recon_if #(
    parameter int W  = 36,
    parameter int RW = 7
);
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  q_in;
    logic [RW-1:0] r_in;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  x_out;
    logic          ovf;
    logic          rem_err;

    modport master (
        output in_valid, q_in, r_in, out_ready,
        input  in_ready, out_valid, x_out, ovf, rem_err
    );

    modport slave (
        input  in_valid, q_in, r_in, out_ready,
        output in_ready, out_valid, x_out, ovf, rem_err
    );
endinterface

// File: rtl/quot_res_recon.sv
// quot_res_recon: rebuilds a dividend x = q*D + r from a quotient/residue pair.
// Digit-serial, MSB-first, CHUNK quotient bits per RUN cycle, so a result takes
// W/CHUNK RUN cycles plus one FIN cycle after the accept edge.
// Ports:
//   clk    : clock, all state on the rising edge
//   rst_n  : synchronous active-low reset
//   bus    : slave side of quot_res_recon_if
//            in_valid/in_ready/q_in/r_in     -> operand input (taken only in IDLE)
//            out_valid/out_ready/x_out/ovf/rem_err -> result, held until accepted
// x_out is (q*D + r) mod 2**W; ovf flags a true result above 2**W-1;
// rem_err flags r >= D (the result is still produced).
// W must be a multiple of CHUNK and D must be below 2**RW.
module quot_res_recon #(
    parameter int W     = 36,
    parameter int D     = 113,
    parameter int RW    = 7,
    parameter int CHUNK = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    quot_res_recon_if.slave   bus
);
    localparam int N  = W / CHUNK;
    localparam int AW = W + RW + 1;            // accumulator width
    localparam int SW = AW + CHUNK + 1;        // one RUN step, before truncation
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);
    localparam logic [SW-1:0] DV   = SW'(D);

    typedef enum logic [1:0] {IDLE, RUN, FIN, DONE} state_t;

    state_t         state_q;
    logic [W-1:0]   sr_q;
    logic [RW-1:0]  r_q;
    logic [AW-1:0]  acc_q, acc_d;
    logic [CW-1:0]  cnt_q;
    logic           lost_q, lost_d;
    logic           in_ready_q, out_valid_q, ovf_q, rem_err_q;
    logic [W-1:0]   x_q;

    logic [CHUNK-1:0] digit;
    logic [SW-1:0]    step;
    logic [AW:0]      sum;

    // One Horner step: acc*2^CHUNK + digit*D. Anything that falls off the top of
    // the accumulator is remembered so ovf stays exact for any parameter choice.
    always_comb begin
        digit  = sr_q[W-1 -: CHUNK];
        step   = (SW'(acc_q) << CHUNK) + SW'(digit) * DV;
        acc_d  = step[AW-1:0];
        lost_d = |step[SW-1:AW];
        sum    = (AW+1)'(acc_q) + (AW+1)'(r_q);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            sr_q        <= '0;
            r_q         <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            lost_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            x_q         <= '0;
            ovf_q       <= 1'b0;
            rem_err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        sr_q       <= bus.q_in;
                        r_q        <= bus.r_in;
                        acc_q      <= '0;
                        cnt_q      <= '0;
                        lost_q     <= 1'b0;
                        in_ready_q <= 1'b0;
                        state_q    <= RUN;
                    end
                end
                RUN: begin
                    acc_q  <= acc_d;
                    lost_q <= lost_q | lost_d;
                    sr_q   <= sr_q << CHUNK;
                    cnt_q  <= cnt_q + 1'b1;
                    if (cnt_q == LAST) state_q <= FIN;
                end
                FIN: begin
                    x_q         <= sum[W-1:0];
                    ovf_q       <= (|sum[AW:W]) | lost_q;
                    rem_err_q   <= ({1'b0, r_q} >= (RW+1)'(D));
                    out_valid_q <= 1'b1;
                    state_q     <= DONE;
                end
                DONE: begin
                    // x_out/flags are left alone here so they persist until the next FIN
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    in_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.x_out     = x_q;
    assign bus.ovf       = ovf_q;
    assign bus.rem_err   = rem_err_q;
endmodule

// File: tb/tb_quot_res_recon.sv
module tb_quot_res_recon;
    localparam int W = 36;
    localparam int RW = 7;
    localparam int LAT = 13;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_pass = 0;

    quot_res_recon_if #(.W(W), .RW(RW)) bus ();

    quot_res_recon #(.W(W), .D(113), .RW(RW), .CHUNK(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    // Reference: plain arithmetic on a 64-bit integer.
    function automatic logic [W-1:0] ref_x(input logic [W-1:0] q, input logic [RW-1:0] r);
        longint unsigned full;
        full = longint'(q) * 113 + longint'(r);
        return full[W-1:0];
    endfunction

    function automatic logic ref_ovf(input logic [W-1:0] q, input logic [RW-1:0] r);
        longint unsigned full;
        full = longint'(q) * 113 + longint'(r);
        return full > 64'h0000_000F_FFFF_FFFF;
    endfunction

    function automatic logic ref_rerr(input logic [RW-1:0] r);
        return int'(r) >= 113;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accepts one operand pair and returns the number of edges from the accept
    // edge until out_valid is seen (0 if it never rose within the budget).
    task automatic start_op(input logic [W-1:0] q, input logic [RW-1:0] r, output int lat);
        int waited;
        waited = 0;
        while (!bus.in_ready && waited < 50) begin
            tick();
            waited++;
        end
        bus.in_valid = 1'b1;
        bus.q_in     = q;
        bus.r_in     = r;
        tick();
        bus.in_valid = 1'b0;
        bus.q_in     = {$urandom_range(0, 15), $urandom};
        bus.r_in     = RW'($urandom);
        lat = 0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (bus.out_valid) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic finish_op();
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        n_chk++;
        if ({bus.in_ready, bus.out_valid, bus.ovf, bus.rem_err} !== 4'b1000 || bus.x_out !== '0)
            $display("FAIL reset: got rdy=%b vld=%b x=%h ovf=%b rerr=%b, expected rdy=1 vld=0 x=0 ovf=0 rerr=0",
                     bus.in_ready, bus.out_valid, bus.x_out, bus.ovf, bus.rem_err);
        else n_pass++;
    endtask

    task automatic test_zero();
        int lat;
        start_op('0, '0, lat);
        n_chk++;
        if (lat !== LAT) $display("FAIL zero_latency: got %0d, expected %0d", lat, LAT);
        else n_pass++;
        n_chk++;
        if ({bus.x_out, bus.ovf, bus.rem_err} !== {36'h0, 2'b00})
            $display("FAIL zero_result: got x=%h ovf=%b rerr=%b, expected 0/0/0", bus.x_out, bus.ovf, bus.rem_err);
        else n_pass++;
        finish_op();
        n_chk++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0)
            $display("FAIL zero_release: got rdy=%b vld=%b, expected rdy=1 vld=0", bus.in_ready, bus.out_valid);
        else n_pass++;
    endtask

    task automatic test_vectors();
        logic [W-1:0]  qv [6];
        logic [RW-1:0] rv [6];
        int lat;
        qv[0] = 36'd1;          rv[0] = 7'd112;
        qv[1] = 36'd608136962;  rv[1] = 7'd29;
        qv[2] = 36'd608136962;  rv[2] = 7'd30;
        qv[3] = 36'hFFFFFFFFF;  rv[3] = 7'd0;
        qv[4] = 36'd5;          rv[4] = 7'd113;
        qv[5] = 36'd608136963;  rv[5] = 7'd127;
        for (int k = 0; k < 6; k++) begin
            start_op(qv[k], rv[k], lat);
            n_chk++;
            if (lat !== LAT || bus.x_out !== ref_x(qv[k], rv[k]) || bus.ovf !== ref_ovf(qv[k], rv[k])
                || bus.rem_err !== ref_rerr(rv[k]))
                $display("FAIL vector%0d: got lat=%0d x=%h ovf=%b rerr=%b, expected lat=%0d x=%h ovf=%b rerr=%b",
                         k, lat, bus.x_out, bus.ovf, bus.rem_err, LAT, ref_x(qv[k], rv[k]),
                         ref_ovf(qv[k], rv[k]), ref_rerr(rv[k]));
            else n_pass++;
            finish_op();
        end
    endtask

    task automatic test_backpressure();
        int lat;
        logic [W-1:0] ex;
        int bad;
        ex = ref_x(36'd12345, 7'd77);
        start_op(36'd12345, 7'd77, lat);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            bus.in_valid = i[0];
            bus.q_in = {$urandom_range(0, 15), $urandom};
            tick();
            if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.x_out !== ex
                || bus.ovf !== 1'b0 || bus.rem_err !== 1'b0) bad++;
        end
        bus.in_valid = 1'b0;
        n_chk++;
        if (bad != 0) $display("FAIL backpressure_hold: got %0d unstable cycles, expected 0", bad);
        else n_pass++;
        finish_op();
        n_chk++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0)
            $display("FAIL backpressure_release: got rdy=%b vld=%b, expected rdy=1 vld=0", bus.in_ready, bus.out_valid);
        else n_pass++;
        tick();
        tick();
        n_chk++;
        if (bus.x_out !== ex || bus.in_ready !== 1'b1)
            $display("FAIL result_persist: got x=%h rdy=%b, expected x=%h rdy=1", bus.x_out, bus.in_ready, ex);
        else n_pass++;
    endtask

    task automatic test_reset_mid_run();
        int lat;
        int seen;
        bus.in_valid = 1'b1;
        bus.q_in = 36'd999999;
        bus.r_in = 7'd3;
        tick();
        bus.in_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        n_chk++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0)
            $display("FAIL midrun_reset: got rdy=%b vld=%b, expected rdy=1 vld=0", bus.in_ready, bus.out_valid);
        else n_pass++;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.out_valid) seen++;
        end
        n_chk++;
        if (seen != 0) $display("FAIL midrun_no_output: got %0d valid cycles, expected 0", seen);
        else n_pass++;
        start_op(36'd424242, 7'd100, lat);
        n_chk++;
        if (lat !== LAT || bus.x_out !== ref_x(36'd424242, 7'd100) || bus.ovf !== 1'b0)
            $display("FAIL midrun_recover: got lat=%0d x=%h ovf=%b, expected lat=%0d x=%h ovf=0",
                     lat, bus.x_out, bus.ovf, LAT, ref_x(36'd424242, 7'd100));
        else n_pass++;
        finish_op();
    endtask

    // Back-to-back random operations; half keep q in the non-overflowing range
    // so the round trip is exercised, the rest hit the wrap/overflow path.
    task automatic test_random();
        logic [W-1:0]  q;
        logic [RW-1:0] r;
        int lat;
        for (int n = 0; n < 2000; n++) begin
            if (n[0]) q = 36'($urandom_range(0, 608136962));
            else      q = {$urandom_range(0, 15), $urandom};
            r = RW'($urandom_range(0, 112));
            start_op(q, r, lat);
            n_chk++;
            if (lat !== LAT || bus.x_out !== ref_x(q, r) || bus.ovf !== ref_ovf(q, r) || bus.rem_err !== 1'b0)
                $display("FAIL random%0d q=%h r=%0d: got lat=%0d x=%h ovf=%b rerr=%b, expected lat=%0d x=%h ovf=%b rerr=0",
                         n, q, r, lat, bus.x_out, bus.ovf, bus.rem_err, LAT, ref_x(q, r), ref_ovf(q, r));
            else n_pass++;
            finish_op();
        end
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.q_in      = '0;
        bus.r_in      = '0;
        bus.out_ready = 1'b0;
        test_reset();
        test_zero();
        test_vectors();
        test_backpressure();
        test_reset_mid_run();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
